// File: rtl/clock_pkg.sv
// Shared state type and default parameters for the CPU clock controller.
// Optional button debounce is selected by defining CLK_DEBOUNCE_EN.
package clock_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_HALT = 2'd2
  } clk_state_t;

  localparam int unsigned DIV_W_DEF           = 24;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/button_debounce.sv
// Step-button conditioner: synchroniser, debounce when CLK_DEBOUNCE_EN is defined, press edge detect.
// press_o is a one-cycle strobe; a button held through reset is ignored until released.
module button_debounce
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync_lvl;
  logic                   filled;
  logic                   level;
  logic                   prev_q;
  logic                   armed_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign filled   = fill_q[SYNC_STAGES-1];

  // fill_q tracks when sync_lvl holds a real sample rather than the reset value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= btn_i;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
    end
  end

`ifdef CLK_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] db_cnt_d;
  logic             db_lvl_q;
  logic             db_lvl_d;

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync_lvl != db_lvl_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_lvl_d = sync_lvl;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign level = db_lvl_q;
`else
  assign level = sync_lvl;
`endif

  // armed_q only sets once a genuine released sample has been seen after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= level;
      if (filled && !sync_lvl) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign press_o = level & ~prev_q & armed_q;

endmodule

// File: rtl/clock_ctrl.sv
// CPU clock generator: continuous divided clock or manual single step, with halt.
// Button debounce is included when CLK_DEBOUNCE_EN is defined.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DIV_W           = DIV_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             step_btn,
  input  logic             halt,
  input  logic [DIV_W-1:0] div,
  output logic             cpu_clk,
  output logic             cpu_rise,
  output logic             cpu_fall,
  output logic             halted
);

  clk_state_t       state_q;
  clk_state_t       state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             clk_q;
  logic             rise_q;
  logic             fall_q;
  logic             halted_q;
  logic             press;
  logic             phase_end;

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .btn_i   (step_btn),
    .press_o (press)
  );

  assign phase_end = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    div_d   = div_q;
    case (state_q)
      S_LOW: begin
        if (halt) begin
          state_d = S_HALT;
          cnt_d   = '0;
        end else if (phase_end) begin
          if (!mode || press) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            div_d   = div;
          end else begin
            cnt_d = cnt_q;  // manual idle: low phase done, wait for a press
          end
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          if (halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_LOW;
            div_d   = div;
          end
        end
      end
      S_HALT: begin
        cnt_d = '0;
        if (!halt) begin
          state_d = S_LOW;
          div_d   = div;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      div_q    <= div;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      clk_q    <= (state_d == S_HIGH);
      rise_q   <= (state_d == S_HIGH) && (state_q != S_HIGH);
      fall_q   <= (state_q == S_HIGH) && (state_d != S_HIGH);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign cpu_clk  = clk_q;
  assign cpu_rise = rise_q;
  assign cpu_fall = fall_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: continuous clocking, div change, halt, manual step, reset, debounce.
module tb_clock_ctrl;

  localparam int DIV_W = 8;
  localparam int DEB   = 8;
  localparam int SYNC  = 2;
`ifdef CLK_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  // expected {cpu_clk, cpu_rise, cpu_fall, halted}
  localparam logic [3:0] L  = 4'b0000;
  localparam logic [3:0] R  = 4'b1100;
  localparam logic [3:0] H  = 4'b1000;
  localparam logic [3:0] F  = 4'b0010;
  localparam logic [3:0] T  = 4'b0001;
  localparam logic [3:0] TF = 4'b0011;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             step_btn;
  logic             halt;
  logic [DIV_W-1:0] div;
  logic             cpu_clk;
  logic             cpu_rise;
  logic             cpu_fall;
  logic             halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             rst;
    logic             mode;
    logic             halt;
    logic [DIV_W-1:0] div;
    logic [3:0]       want;
  } vec_t;

  vec_t tbl[$];

  clock_ctrl #(
    .DIV_W           (DIV_W),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .mode     (mode),
    .step_btn (step_btn),
    .halt     (halt),
    .div      (div),
    .cpu_clk  (cpu_clk),
    .cpu_rise (cpu_rise),
    .cpu_fall (cpu_fall),
    .halted   (halted)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void addn(input int n, input logic r, input logic m, input logic h,
                               input logic [DIV_W-1:0] d, input logic [3:0] w);
    vec_t v;
    v.rst  = r;
    v.mode = m;
    v.halt = h;
    v.div  = d;
    v.want = w;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: {clk,rise,fall,halted} got %b want %b", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic step_chk(input string nm, input logic [3:0] want);
    tick();
    chk(nm, {cpu_clk, cpu_rise, cpu_fall, halted}, want);
  endtask

  task automatic do_reset(input logic m, input logic [DIV_W-1:0] d);
    rst  = 1'b1;
    mode = m;
    halt = 1'b0;
    div  = d;
    step_chk("reset", L);
    rst = 1'b0;
  endtask

  // rise and fall strobes must never coincide
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (cpu_rise && cpu_fall) begin
        errors++;
        $display("FAIL rise_fall_overlap: rise=%b fall=%b want not both 1", cpu_rise, cpu_fall);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    mode     = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    div      = 8'd3;

    // continuous, div=3: 8-cycle period; div -> 1 in 2nd cycle of a high phase
    addn(1, 1, 0, 0, 8'd3, L);
    addn(3, 0, 0, 0, 8'd3, L);
    addn(1, 0, 0, 0, 8'd3, R);
    addn(3, 0, 0, 0, 8'd3, H);
    addn(1, 0, 0, 0, 8'd3, F);
    addn(3, 0, 0, 0, 8'd3, L);
    addn(1, 0, 0, 0, 8'd3, R);
    addn(3, 0, 0, 0, 8'd3, H);
    addn(1, 0, 0, 0, 8'd3, F);
    addn(3, 0, 0, 0, 8'd3, L);
    addn(1, 0, 0, 0, 8'd3, R);
    addn(3, 0, 0, 0, 8'd1, H);
    addn(1, 0, 0, 0, 8'd1, F);
    addn(1, 0, 0, 0, 8'd1, L);
    addn(1, 0, 0, 0, 8'd1, R);
    addn(1, 0, 0, 0, 8'd1, H);
    addn(1, 0, 0, 0, 8'd1, F);
    addn(1, 0, 0, 0, 8'd1, L);
    addn(1, 0, 0, 0, 8'd1, R);
    // continuous, div=5: halt in 2nd high cycle, release, then halt during low
    addn(1, 1, 0, 0, 8'd5, L);
    addn(5, 0, 0, 0, 8'd5, L);
    addn(1, 0, 0, 0, 8'd5, R);
    addn(1, 0, 0, 0, 8'd5, H);
    addn(4, 0, 0, 1, 8'd5, H);
    addn(1, 0, 0, 1, 8'd5, TF);
    addn(1, 0, 0, 1, 8'd5, T);
    addn(6, 0, 0, 0, 8'd5, L);
    addn(1, 0, 0, 0, 8'd5, R);
    addn(5, 0, 0, 0, 8'd5, H);
    addn(1, 0, 0, 0, 8'd5, F);
    addn(1, 0, 0, 1, 8'd5, T);
    addn(6, 0, 0, 0, 8'd5, L);
    addn(1, 0, 0, 0, 8'd5, R);

    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].rst;
      mode = tbl[i].mode;
      halt = tbl[i].halt;
      div  = tbl[i].div;
      step_chk($sformatf("tbl[%0d]", i), tbl[i].want);
    end

`ifndef CLK_DEBOUNCE_EN
    // manual step, 1-cycle presses; the second press lands in the high phase
    do_reset(1'b1, 8'd2);
    for (int k = 0; k < 6; k++) step_chk($sformatf("man_idle%0d", k), L);
    step_btn = 1'b1;
    step_chk("man_p1", L);
    step_btn = 1'b0;
    step_chk("man_p2", L);
    step_chk("man_rise", R);
    step_btn = 1'b1;
    step_chk("man_h1", H);
    step_btn = 1'b0;
    step_chk("man_h2", H);
    step_chk("man_fall", F);
    for (int k = 0; k < 8; k++) step_chk($sformatf("man_nopulse%0d", k), L);
    step_btn = 1'b1;
    step_chk("man_q1", L);
    step_btn = 1'b0;
    step_chk("man_q2", L);
    step_chk("man_rise2", R);
    for (int k = 0; k < 2; k++) step_chk($sformatf("man_h2_%0d", k), H);
    step_chk("man_fall2", F);
`else
    // bouncing button, then stable: one pulse, rising SYNC+DEB+1 cycles after last bounce
    do_reset(1'b1, 8'd2);
    for (int k = 0; k < 12; k++) step_chk($sformatf("db_idle%0d", k), L);
    for (int b = 0; b < 4; b++) begin
      step_btn = 1'b1;
      for (int k = 0; k < 3; k++) step_chk($sformatf("db_b%0d_hi%0d", b, k), L);
      step_btn = 1'b0;
      for (int k = 0; k < 3; k++) step_chk($sformatf("db_b%0d_lo%0d", b, k), L);
    end
    step_btn = 1'b1;
    for (int k = 1; k < LAT; k++) step_chk($sformatf("db_wait%0d", k), L);
    step_chk("db_rise", R);
    step_chk("db_h1", H);
    step_chk("db_h2", H);
    step_chk("db_fall", F);
    for (int k = 0; k < 10; k++) step_chk($sformatf("db_once%0d", k), L);
    step_btn = 1'b0;
    for (int k = 0; k < 15; k++) step_chk($sformatf("db_rel%0d", k), L);
`endif

    // reset mid-high with the button held: no pulse until release and re-press
    do_reset(1'b1, 8'd2);
    for (int k = 0; k < 12; k++) step_chk($sformatf("rst_idle%0d", k), L);
    step_btn = 1'b1;
    for (int k = 1; k < LAT; k++) step_chk($sformatf("rst_lat%0d", k), L);
    step_chk("rst_rise", R);
    step_chk("rst_high", H);
    rst = 1'b1;
    step_chk("rst_mid_high", L);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step_chk($sformatf("rst_held%0d", k), L);
    step_btn = 1'b0;
    for (int k = 0; k < 15; k++) step_chk($sformatf("rst_rel%0d", k), L);
    step_btn = 1'b1;
    for (int k = 1; k < LAT; k++) step_chk($sformatf("rst_re%0d", k), L);
    step_chk("rst_repress_rise", R);
    step_btn = 1'b0;
    step_chk("rst_repress_high", H);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
